// File: rtl/baccarat_dealer_if.sv
// Load strobes from the game statemachine and the card/score results returned to it.
// The statemachine side uses the master modport and the dealer datapath uses the slave modport.
interface baccarat_dealer_if #(
  parameter int CARD_W = 4
);
  logic              load_pcard1;
  logic              load_pcard2;
  logic              load_pcard3;
  logic              load_dcard1;
  logic              load_dcard2;
  logic              load_dcard3;
  logic [CARD_W-1:0] pcard1;
  logic [CARD_W-1:0] pcard2;
  logic [CARD_W-1:0] pcard3;
  logic [CARD_W-1:0] dcard1;
  logic [CARD_W-1:0] dcard2;
  logic [CARD_W-1:0] dcard3;
  logic [CARD_W-1:0] pscore;
  logic [CARD_W-1:0] dscore;
  logic [2:0]        cards_dealt;
  logic              proto_err;

  modport master (
    output load_pcard1, load_pcard2, load_pcard3,
    output load_dcard1, load_dcard2, load_dcard3,
    input  pcard1, pcard2, pcard3, dcard1, dcard2, dcard3,
    input  pscore, dscore, cards_dealt, proto_err
  );

  modport slave (
    input  load_pcard1, load_pcard2, load_pcard3,
    input  load_dcard1, load_dcard2, load_dcard3,
    output pcard1, pcard2, pcard3, dcard1, dcard2, dcard3,
    output pscore, dscore, cards_dealt, proto_err
  );
endinterface

// File: rtl/baccarat_dealer.sv
// Baccarat card dealer: card source, six card registers, hand scores and deal-order checking.
// Optional macro SHOE_LFSR_EN replaces the incrementing card counter with an 8-bit LFSR shoe.
module baccarat_dealer #(
  parameter int CARD_MAX = 13,
  parameter int CARD_W   = 4
) (
  input  logic              slow_clock,
  input  logic              reset,
  baccarat_dealer_if.slave  dealer
);

  typedef enum logic [2:0] {EMPTY, P1, D1, P2, D2, P3, D3} phase_t;

  // Strobe vector bit order: player cards 1..3, then dealer cards 1..3.
  localparam logic [5:0] S_P1 = 6'b000001;
  localparam logic [5:0] S_P2 = 6'b000010;
  localparam logic [5:0] S_P3 = 6'b000100;
  localparam logic [5:0] S_D1 = 6'b001000;
  localparam logic [5:0] S_D2 = 6'b010000;
  localparam logic [5:0] S_D3 = 6'b100000;

  phase_t            phase_q, phase_d;
  logic [CARD_W-1:0] pcard_q [3];
  logic [CARD_W-1:0] dcard_q [3];
  logic [2:0]        cards_dealt_q;
  logic              proto_err_q;
  logic [CARD_W-1:0] card_now;
  logic [5:0]        strb;
  logic              legal;

  assign strb = {dealer.load_dcard3, dealer.load_dcard2, dealer.load_dcard1,
                 dealer.load_pcard3, dealer.load_pcard2, dealer.load_pcard1};

`ifdef SHOE_LFSR_EN
  logic [7:0] lfsr_q;

  assign card_now = CARD_W'((lfsr_q % 8'(CARD_MAX)) + 8'd1);

  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) lfsr_q <= 8'h01;
    else       lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end
`else
  logic [CARD_W-1:0] new_card_q;

  assign card_now = new_card_q;

  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset)                               new_card_q <= CARD_W'(1);
    else if (new_card_q == CARD_W'(CARD_MAX)) new_card_q <= CARD_W'(1);
    else                                     new_card_q <= new_card_q + CARD_W'(1);
  end
`endif

  // Only an exact one-hot match against the phase's allowed strobe counts as legal,
  // so simultaneous strobes fall through to the error path automatically.
  always_comb begin
    legal   = 1'b0;
    phase_d = phase_q;
    unique case (phase_q)
      EMPTY: if (strb == S_P1) begin legal = 1'b1; phase_d = P1; end
      P1:    if (strb == S_D1) begin legal = 1'b1; phase_d = D1; end
      D1:    if (strb == S_P2) begin legal = 1'b1; phase_d = P2; end
      P2:    if (strb == S_D2) begin legal = 1'b1; phase_d = D2; end
      D2: begin
        if (strb == S_P3)      begin legal = 1'b1; phase_d = P3; end
        else if (strb == S_D3) begin legal = 1'b1; phase_d = D3; end
      end
      P3:    if (strb == S_D3) begin legal = 1'b1; phase_d = D3; end
      D3:    legal = 1'b0;
      default: legal = 1'b0;
    endcase
  end

  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) begin
      phase_q       <= EMPTY;
      pcard_q       <= '{default: '0};
      dcard_q       <= '{default: '0};
      cards_dealt_q <= 3'd0;
      proto_err_q   <= 1'b0;
    end else if (legal) begin
      phase_q       <= phase_d;
      cards_dealt_q <= cards_dealt_q + 3'd1;
      for (int i = 0; i < 3; i++) begin
        if (strb[i])     pcard_q[i] <= card_now;
        if (strb[i + 3]) dcard_q[i] <= card_now;
      end
    end else if (|strb) begin
      proto_err_q <= 1'b1;
    end
  end

  function automatic logic [4:0] card_val(input logic [CARD_W-1:0] c);
    return (c != '0 && c <= CARD_W'(9)) ? 5'(c) : 5'd0;
  endfunction

  logic [4:0] psum, dsum;
  assign psum = card_val(pcard_q[0]) + card_val(pcard_q[1]) + card_val(pcard_q[2]);
  assign dsum = card_val(dcard_q[0]) + card_val(dcard_q[1]) + card_val(dcard_q[2]);

  assign dealer.pscore      = CARD_W'(psum % 5'd10);
  assign dealer.dscore      = CARD_W'(dsum % 5'd10);
  assign dealer.pcard1      = pcard_q[0];
  assign dealer.pcard2      = pcard_q[1];
  assign dealer.pcard3      = pcard_q[2];
  assign dealer.dcard1      = dcard_q[0];
  assign dealer.dcard2      = dcard_q[1];
  assign dealer.dcard3      = dcard_q[2];
  assign dealer.cards_dealt = cards_dealt_q;
  assign dealer.proto_err   = proto_err_q;

endmodule

// File: tb/tb_baccarat_dealer.sv
// Directed bench for baccarat_dealer: a deal-order model checked every cycle plus literal expectations.
module tb_baccarat_dealer;

  localparam logic [5:0] S_P1 = 6'b000001;
  localparam logic [5:0] S_P2 = 6'b000010;
  localparam logic [5:0] S_P3 = 6'b000100;
  localparam logic [5:0] S_D1 = 6'b001000;
  localparam logic [5:0] S_D2 = 6'b010000;
  localparam logic [5:0] S_D3 = 6'b100000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] strb = '0;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  baccarat_dealer_if #(.CARD_W(4)) dif ();

  assign dif.load_pcard1 = strb[0];
  assign dif.load_pcard2 = strb[1];
  assign dif.load_pcard3 = strb[2];
  assign dif.load_dcard1 = strb[3];
  assign dif.load_dcard2 = strb[4];
  assign dif.load_dcard3 = strb[5];

  baccarat_dealer #(.CARD_MAX(13), .CARD_W(4)) dut (
    .slow_clock (clk),
    .reset      (rst),
    .dealer     (dif)
  );

  // Model: edge count since reset, deal position 0..6 in the legal order, dealt cards.
  int m_n, m_pos, m_dealt, m_err;
  int m_pc [3];
  int m_dc [3];

  // Next deal position for a strobe index (0..2 player, 3..5 dealer), or -1 if out of order.
  function automatic int next_pos(input int pos, input int which);
    case (pos)
      0: return (which == 0) ? 1 : -1;
      1: return (which == 3) ? 2 : -1;
      2: return (which == 1) ? 3 : -1;
      3: return (which == 4) ? 4 : -1;
      4: return (which == 2) ? 5 : (which == 5) ? 6 : -1;
      5: return (which == 5) ? 6 : -1;
      default: return -1;
    endcase
  endfunction

  function automatic int worth(input int c);
    return (c >= 1 && c <= 9) ? c : 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_n = 0; m_pos = 0; m_dealt = 0; m_err = 0;
      for (int i = 0; i < 3; i++) begin m_pc[i] = 0; m_dc[i] = 0; end
    end else begin
      int card, ones, which, nx;
      m_n++;
      card  = ((m_n - 1) % 13) + 1;
      ones  = $countones(strb);
      which = 0;
      for (int i = 0; i < 6; i++) if (strb[i]) which = i;
      if (ones > 1) m_err = 1;
      else if (ones == 1) begin
        nx = next_pos(m_pos, which);
        if (nx < 0) m_err = 1;
        else begin
          if (which < 3) m_pc[which] = card;
          else           m_dc[which - 3] = card;
          m_pos = nx;
          m_dealt++;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("pcard1", int'(dif.pcard1), m_pc[0]);
    chk("pcard2", int'(dif.pcard2), m_pc[1]);
    chk("pcard3", int'(dif.pcard3), m_pc[2]);
    chk("dcard1", int'(dif.dcard1), m_dc[0]);
    chk("dcard2", int'(dif.dcard2), m_dc[1]);
    chk("dcard3", int'(dif.dcard3), m_dc[2]);
    chk("pscore", int'(dif.pscore), (worth(m_pc[0]) + worth(m_pc[1]) + worth(m_pc[2])) % 10);
    chk("dscore", int'(dif.dscore), (worth(m_dc[0]) + worth(m_dc[1]) + worth(m_dc[2])) % 10);
    chk("cards_dealt", int'(dif.cards_dealt), m_dealt);
    chk("proto_err", int'(dif.proto_err), m_err);
  end

  // Called at a negedge; strobes cover exactly one rising edge and the call returns at the next negedge.
  task automatic edge_with(input logic [5:0] s);
    strb = s;
    @(negedge clk);
    $display("edge strobes=%b pc=%0d/%0d/%0d dc=%0d/%0d/%0d ps=%0d ds=%0d n=%0d err=%0d",
             s, dif.pcard1, dif.pcard2, dif.pcard3, dif.dcard1, dif.dcard2, dif.dcard3,
             dif.pscore, dif.dscore, dif.cards_dealt, dif.proto_err);
    strb = '0;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    strb = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    #1;
    chk("rst pcard1", int'(dif.pcard1), 0);
    chk("rst cards_dealt", int'(dif.cards_dealt), 0);
    #1;

    // Full deal in order.
    edge_with(S_P1); edge_with(S_D1); edge_with(S_P2); edge_with(S_D2);
    #1;
    chk("t1 pcard1", int'(dif.pcard1), 1);
    chk("t1 dcard1", int'(dif.dcard1), 2);
    chk("t1 pcard2", int'(dif.pcard2), 3);
    chk("t1 dcard2", int'(dif.dcard2), 4);
    chk("t1 pscore", int'(dif.pscore), 4);
    chk("t1 dscore", int'(dif.dscore), 6);
    chk("t1 dealt", int'(dif.cards_dealt), 4);
    chk("t1 err", int'(dif.proto_err), 0);
    edge_with(S_P3);
    #1;
    chk("t1 pcard3", int'(dif.pcard3), 5);
    chk("t1 pscore3", int'(dif.pscore), 9);
    edge_with(S_D3);
    #1;
    chk("t1 dcard3", int'(dif.dcard3), 6);
    chk("t1 dscore3", int'(dif.dscore), 2);
    chk("t1 dealt6", int'(dif.cards_dealt), 6);
    edge_with(S_P1);
    #1;
    chk("t1 late err", int'(dif.proto_err), 1);
    chk("t1 pcard1 kept", int'(dif.pcard1), 1);

    // Face cards and source wrap, plus D2 -> D3 skipping P3.
    do_reset();
    for (int i = 0; i < 9; i++) edge_with(6'b0);
    edge_with(S_P1); edge_with(S_D1); edge_with(S_P2); edge_with(S_D2);
    #1;
    chk("t2 pcard1", int'(dif.pcard1), 10);
    chk("t2 dcard2", int'(dif.dcard2), 13);
    chk("t2 pscore", int'(dif.pscore), 0);
    chk("t2 dscore", int'(dif.dscore), 0);
    edge_with(S_D3);
    #1;
    chk("t2 dcard3 wrap", int'(dif.dcard3), 1);
    chk("t2 dscore", int'(dif.dscore), 1);

    // Out-of-order strobe, then recovery.
    do_reset();
    edge_with(S_P2);
    #1;
    chk("t3 err", int'(dif.proto_err), 1);
    chk("t3 pcard2", int'(dif.pcard2), 0);
    chk("t3 dealt", int'(dif.cards_dealt), 0);
    edge_with(S_P1);
    #1;
    chk("t3 pcard1", int'(dif.pcard1), 2);
    chk("t3 dealt1", int'(dif.cards_dealt), 1);
    chk("t3 err sticky", int'(dif.proto_err), 1);

    // Two strobes on one edge.
    do_reset();
    edge_with(S_P1 | S_D1);
    #1;
    chk("t4 err", int'(dif.proto_err), 1);
    chk("t4 pcard1", int'(dif.pcard1), 0);
    chk("t4 dcard1", int'(dif.dcard1), 0);
    chk("t4 dealt", int'(dif.cards_dealt), 0);

    // Asynchronous reset mid-deal.
    do_reset();
    edge_with(S_P1); edge_with(S_D1); edge_with(S_P2);
    #2;
    rst = 1'b1;
    #1;
    chk("t5 async pcard1", int'(dif.pcard1), 0);
    chk("t5 async dcard1", int'(dif.dcard1), 0);
    chk("t5 async pscore", int'(dif.pscore), 0);
    chk("t5 async dscore", int'(dif.dscore), 0);
    chk("t5 async dealt", int'(dif.cards_dealt), 0);
    @(negedge clk);
    rst = 1'b0;
    edge_with(S_P1);
    #1;
    chk("t5 reload pcard1", int'(dif.pcard1), 1);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/baccarat_dealer.md
Name: baccarat_dealer

Overview:
Card-dealing datapath that responds to the load strobes issued by the baccarat game statemachine. It owns the card source, six card registers and the hand-score logic. It returns pscore, dscore and pcard3 to the statemachine and drives card values to the display logic. It also checks that load strobes arrive in legal deal order.

Parameters:
CARD_MAX, 13, highest rank produced by the card source (cards are 1..CARD_MAX).
CARD_W, 4, width of every card and score bus.

Ports:
slow_clock  in  1  game clock; all state updates on its rising edge.
reset  in  1  asynchronous, active-high reset.
load_pcard1  in  1  load player card 1 from the card source.
load_pcard2  in  1  load player card 2.
load_pcard3  in  1  load player card 3.
load_dcard1  in  1  load dealer card 1.
load_dcard2  in  1  load dealer card 2.
load_dcard3  in  1  load dealer card 3.
pcard1, pcard2, pcard3  out  CARD_W  player card registers; 0 = not dealt.
dcard1, dcard2, dcard3  out  CARD_W  dealer card registers; 0 = not dealt.
pscore  out  CARD_W  player hand score, 0..9.
dscore  out  CARD_W  dealer hand score, 0..9.
cards_dealt  out  3  number of cards legally loaded, 0..6.
proto_err  out  1  sticky flag for an illegal load sequence.

Behaviour:
- Reset is asynchronous and active-high. While reset is high, all six card registers = 0, pscore = dscore = 0, cards_dealt = 0, proto_err = 0, card source = 1 and deal phase = EMPTY. These values hold immediately, with no clock edge needed. This applies mid-deal as well.
- Card source: register new_card, reset value 1. It advances +1 on every rising edge, whether or not a load occurs. It wraps from CARD_MAX to 1 and never produces 0.
- Load: on the edge where exactly one strobe is high and the strobe is legal, the selected register captures the pre-increment new_card. On a clock edge numbered n after reset is released, the loaded value is ((n-1) mod 13)+1.
- Card value: rank 1..9 is worth its face value; ranks 10..13 and 0 are worth 0.
- Scores are combinational from the registers. pscore = (val(pcard1)+val(pcard2)+val(pcard3)) mod 10, and dscore is computed the same way from the dealer cards. Use a 5-bit intermediate sum, maximum 27. Scores are valid in the same cycle as a register update, with no added latency.
- Deal phase FSM states: EMPTY, P1, D1, P2, D2, P3, D3.
- Legal transitions:
  - EMPTY -load_pcard1-> P1
  - P1 -load_dcard1-> D1
  - D1 -load_pcard2-> P2
  - P2 -load_dcard2-> D2
  - D2 -load_pcard3-> P3
  - D2 -load_dcard3-> D3
  - P3 -load_dcard3-> D3
- D3 is terminal; any load in D3 is illegal.
- cards_dealt increments by 1 on every legal load.
- Illegal load rules:
  - A strobe not legal in the current phase sets proto_err.
  - Two or more strobes high on the same edge set proto_err.
  - In both cases no register is written, and neither the phase nor cards_dealt changes.
  - proto_err stays set until reset.
- No strobes high: registers, phase and cards_dealt hold. Only new_card advances.
- Subsequent legal loads are still accepted after proto_err is set.

Optional Feature:
SHOE_LFSR_EN
- Defined: the card source is an 8-bit Fibonacci LFSR with taps x^8+x^6+x^5+x^4+1 and seed 8'h01. It shifts every edge. new_card = (lfsr mod CARD_MAX)+1. All other behaviour is unchanged.
- Undefined: the card source is the incrementing counter described above.
- Test Plan values assume the macro is undefined.

Test Plan:
- Reset, then load P1, D1, P2, D2 on edges 1-4 -> pcard1=1, dcard1=2, pcard2=3, dcard2=4, pscore=4, dscore=6, cards_dealt=4, proto_err=0.
- Continue with P3 on edge 5, then D3 on edge 6 -> pcard3=5, pscore=9, dcard3=6, dscore=2, cards_dealt=6. A further load_pcard1 on edge 7 -> proto_err=1, pcard1 still 1.
- Reset, 9 idle edges, then P1, D1, P2, D2 on edges 10-13 -> cards 10, 11, 12, 13, pscore=0, dscore=0. A D3 load on edge 14 captures 1, confirming the wrap, and gives dscore=1.
- Reset, then load_pcard2 on edge 1 -> proto_err=1, pcard2=0, cards_dealt=0. Then load_pcard1 on edge 2 -> pcard1=2, cards_dealt=1, proto_err stays 1.
- Reset, then load_pcard1 and load_dcard1 together on edge 1 -> proto_err=1, both registers 0, cards_dealt=0.
- After 3 legal loads, assert reset between edges -> all outputs 0 immediately with no clock edge. After release, P1 on the next edge loads 1.
